// File: rtl/ifu_fetch_way0.sv
// Way-0 fetch stage: single-outstanding instruction bus read feeding a
// small PC+instruction FIFO for decode, with jump-flush support.
module ifu_fetch_way0 #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pc_valid_i,
    input  logic              pc_req_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic              ready_o,
    output logic              data_ok_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [DATA_W-1:0] bus_rdata_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    input  logic              id_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               data_ok_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [DATA_W-1:0]  data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  pc_mem   [FIFO_DEPTH];
    logic               accept;
    logic               push;
    logic               pop;

    // Only one fetch is ever in flight, so checking count here is enough
    // to guarantee room for the word when it returns.
    assign ready_o = (state_q == IDLE) && (count < CNT_W'(FIFO_DEPTH)) && !flush_i;
    assign accept  = pc_valid_i && pc_req_i && ready_o;
    assign push    = (state_q == WAIT) && bus_rvalid_i && !flush_i;
    assign pop     = inst_valid_o && id_ready_i && !flush_i;

    assign bus_req_o    = (state_q == REQ);
    assign bus_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
    assign data_ok_o    = data_ok_q;
    assign inst_valid_o = (count != '0);
    assign inst_o       = data_mem[rd_ptr];
    assign inst_pc_o    = pc_mem[rd_ptr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (bus_gnt_i && flush_i)  state_d = DROP;
                else if (bus_gnt_i)        state_d = WAIT;
                else if (flush_i)          state_d = IDLE;
            end
            WAIT: begin
                if (bus_rvalid_i)          state_d = IDLE;
                else if (flush_i)          state_d = DROP;
            end
            DROP: if (bus_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_ok_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_ok_q <= push;
            if (accept) addr_q <= pc_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= bus_rdata_i;
                pc_mem[wr_ptr]   <= addr_q;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_way0.sv
// Directed bench for ifu_fetch_way0: per-cycle vector table plus
// hand-written FIFO-full, flush-with-pop and mid-transaction reset cases.
module tb_ifu_fetch_way0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pc_valid_i = 1'b0;
    logic        pc_req_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o;
    logic        data_ok_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_gnt_i = 1'b0;
    logic        bus_rvalid_i = 1'b0;
    logic [31:0] bus_rdata_i = '0;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        id_ready_i = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifu_fetch_way0 #(.FIFO_DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .pc_valid_i(pc_valid_i), .pc_req_i(pc_req_i), .pc_i(pc_i),
        .flush_i(flush_i), .ready_o(ready_o), .data_ok_o(data_ok_o),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o),
        .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
        .bus_rdata_i(bus_rdata_i), .inst_valid_o(inst_valid_o),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .id_ready_i(id_ready_i)
    );

    typedef struct {
        logic        pv, preq;
        logic [31:0] pc;
        logic        fl, gnt, rv;
        logic [31:0] rd;
        logic        idr;
        logic        e_rdy, e_dok, e_breq;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst, e_ipc;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        pc_valid_i = 0; pc_req_i = 0; flush_i = 0;
        bus_gnt_i = 0; bus_rvalid_i = 0;
    endtask

    // Accept, grant next cycle, data the cycle after; ends at the negedge
    // following the push so data_ok_o is visible.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        pc_valid_i = 1; pc_req_i = 1; pc_i = a;
        #1 chk("fetch_ready", {31'b0, ready_o}, 32'd1);
        @(negedge clk);
        pc_valid_i = 0; pc_req_i = 0; bus_gnt_i = 1;
        @(negedge clk);
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = d;
        @(negedge clk);
        bus_rvalid_i = 0;
    endtask

    initial begin
        vecs[0]  = '{1,1,32'h100,0,0,0,32'h0,0,          1,0,0,32'h0,  0,32'h0,32'h0};
        vecs[1]  = '{0,0,32'h0,  0,1,0,32'h0,0,          0,0,1,32'h100,0,32'h0,32'h0};
        vecs[2]  = '{0,0,32'h0,  0,0,0,32'h0,0,          0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[3]  = '{0,0,32'h0,  0,0,1,32'h13,0,         0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[4]  = '{0,0,32'h0,  0,0,0,32'h0,0,          1,1,0,32'h0,  1,32'h13,32'h100};
        vecs[5]  = '{0,0,32'h0,  0,0,0,32'h0,1,          1,0,0,32'h0,  1,32'h13,32'h100};
        vecs[6]  = '{1,1,32'h300,0,0,0,32'h0,0,          1,0,0,32'h0,  0,32'h0,32'h0};
        vecs[7]  = '{0,0,32'h0,  0,1,0,32'h0,0,          0,0,1,32'h300,0,32'h0,32'h0};
        vecs[8]  = '{0,0,32'h0,  1,0,0,32'h0,0,          0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[9]  = '{0,0,32'h0,  0,0,1,32'hDEADBEEF,0,   0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[10] = '{1,1,32'h200,0,0,0,32'h0,0,          1,0,0,32'h0,  0,32'h0,32'h0};
        vecs[11] = '{0,0,32'h0,  0,1,0,32'h0,0,          0,0,1,32'h200,0,32'h0,32'h0};
        vecs[12] = '{0,0,32'h0,  0,0,1,32'h200AA,0,      0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[13] = '{1,1,32'h400,0,0,0,32'h0,0,          1,1,0,32'h0,  1,32'h200AA,32'h200};
        vecs[14] = '{0,0,32'h0,  1,0,0,32'h0,0,          0,0,1,32'h400,1,32'h200AA,32'h200};
        vecs[15] = '{1,1,32'h102,0,0,0,32'h0,0,          1,0,0,32'h0,  0,32'h0,32'h0};
        vecs[16] = '{0,0,32'h0,  0,1,0,32'h0,0,          0,0,1,32'h100,0,32'h0,32'h0};
        vecs[17] = '{0,0,32'h0,  1,0,1,32'h55,0,         0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[18] = '{1,1,32'h102,0,0,0,32'h0,0,          1,0,0,32'h0,  0,32'h0,32'h0};
        vecs[19] = '{0,0,32'h0,  0,1,0,32'h0,0,          0,0,1,32'h100,0,32'h0,32'h0};
        vecs[20] = '{0,0,32'h0,  0,0,1,32'h66,0,         0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[21] = '{0,0,32'h0,  0,0,0,32'h0,1,          1,1,0,32'h0,  1,32'h66,32'h102};
        vecs[22] = '{1,1,32'h500,0,0,0,32'h0,0,          1,0,0,32'h0,  0,32'h0,32'h0};
        vecs[23] = '{0,0,32'h0,  1,1,0,32'h0,0,          0,0,1,32'h500,0,32'h0,32'h0};
        vecs[24] = '{0,0,32'h0,  1,0,0,32'h0,0,          0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[25] = '{0,0,32'h0,  0,0,1,32'h77,0,         0,0,0,32'h0,  0,32'h0,32'h0};
        vecs[26] = '{0,0,32'h0,  0,0,0,32'h0,0,          1,0,0,32'h0,  0,32'h0,32'h0};

        // Reset state, with a flush pulse held during reset
        flush_i = 1;
        #12;
        chk("rst_breq", {31'b0, bus_req_o}, 32'd0);
        chk("rst_dok", {31'b0, data_ok_o}, 32'd0);
        chk("rst_iv", {31'b0, inst_valid_o}, 32'd0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_ipc", inst_pc_o, 32'h0);
        @(negedge clk);
        flush_i = 0;
        reset_n = 1;

        // Per-cycle vectors: drive at negedge, compare 1ns later
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            pc_valid_i = vecs[i].pv; pc_req_i = vecs[i].preq;
            pc_i = vecs[i].pc; flush_i = vecs[i].fl;
            bus_gnt_i = vecs[i].gnt; bus_rvalid_i = vecs[i].rv;
            bus_rdata_i = vecs[i].rd; id_ready_i = vecs[i].idr;
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, ready_o}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("v%0d_dok", i), {31'b0, data_ok_o}, {31'b0, vecs[i].e_dok});
            chk($sformatf("v%0d_breq", i), {31'b0, bus_req_o}, {31'b0, vecs[i].e_breq});
            chk($sformatf("v%0d_iv", i), {31'b0, inst_valid_o}, {31'b0, vecs[i].e_iv});
            if (vecs[i].e_breq)
                chk($sformatf("v%0d_addr", i), bus_addr_o, vecs[i].e_addr);
            if (vecs[i].e_iv) begin
                chk($sformatf("v%0d_inst", i), inst_o, vecs[i].e_inst);
                chk($sformatf("v%0d_ipc", i), inst_pc_o, vecs[i].e_ipc);
            end
        end
        idle_inputs();
        id_ready_i = 0;

        // FIFO fill to full, then drain in order
        for (int i = 0; i < 4; i++)
            fetch(32'(4 * i), 32'h1000 + 32'(4 * i));
        #1;
        chk("full_ready", {31'b0, ready_o}, 32'd0);
        chk("full_iv", {31'b0, inst_valid_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_inst", i), inst_o, 32'h1000 + 32'(4 * i));
            chk($sformatf("drain%0d_ipc", i), inst_pc_o, 32'(4 * i));
            id_ready_i = 1;
            @(negedge clk);
            id_ready_i = 0;
            #1;
            chk($sformatf("drain%0d_ready", i), {31'b0, ready_o}, 32'd1);
        end
        chk("drain_iv", {31'b0, inst_valid_o}, 32'd0);

        // Three entries held; flush together with pop and rvalid
        for (int i = 0; i < 3; i++)
            fetch(32'h600 + 32'(4 * i), 32'hA0 + 32'(i));
        @(negedge clk);
        pc_valid_i = 1; pc_req_i = 1; pc_i = 32'h700;
        @(negedge clk);
        idle_inputs(); bus_gnt_i = 1;
        @(negedge clk);
        bus_gnt_i = 0; bus_rvalid_i = 1; bus_rdata_i = 32'hBB;
        flush_i = 1; id_ready_i = 1;
        @(negedge clk);
        idle_inputs(); id_ready_i = 0;
        #1;
        chk("t5_iv", {31'b0, inst_valid_o}, 32'd0);
        chk("t5_dok", {31'b0, data_ok_o}, 32'd0);
        chk("t5_ready", {31'b0, ready_o}, 32'd1);
        fetch(32'h800, 32'hCC);
        #1;
        chk("t5_after_inst", inst_o, 32'hCC);
        chk("t5_after_ipc", inst_pc_o, 32'h800);
        chk("t5_after_dok", {31'b0, data_ok_o}, 32'd1);

        // Reset asserted while a fetch waits for data
        @(negedge clk);
        pc_valid_i = 1; pc_req_i = 1; pc_i = 32'h104;
        @(negedge clk);
        idle_inputs(); bus_gnt_i = 1;
        @(negedge clk);
        bus_gnt_i = 0;
        #2 reset_n = 0;
        #1;
        chk("t6_breq", {31'b0, bus_req_o}, 32'd0);
        chk("t6_iv", {31'b0, inst_valid_o}, 32'd0);
        chk("t6_dok", {31'b0, data_ok_o}, 32'd0);
        chk("t6_addr", bus_addr_o, 32'h0);
        chk("t6_inst", inst_o, 32'h0);
        chk("t6_ipc", inst_pc_o, 32'h0);
        @(negedge clk);
        reset_n = 1;
        bus_rvalid_i = 1; bus_rdata_i = 32'hEE;
        @(negedge clk);
        bus_rvalid_i = 0;
        #1;
        chk("t6_late_dok", {31'b0, data_ok_o}, 32'd0);
        chk("t6_late_iv", {31'b0, inst_valid_o}, 32'd0);
        chk("t6_late_ready", {31'b0, ready_o}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
